neuron_mac_16_bit: RTL and testbench

Serial multiply-accumulate neuron for the VAE dense layers: accepts a stream of LEN signed Q4.12 input/weight pairs, accumulates the exact products in a wide accumulator, adds a bias, and saturates the result back to Q4.12. It sits directly upstream of the `softplus_16_bit` activation. Its one-cycle `out_valid` pulse drives the activation's `start`, and `y` drives the activation's `x`, held stable until the next result.

---
 rtl/neuron_mac_16_bit.sv | 111 +++++++++++
 tb/tb_neuron_mac_16_bit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_16_bit.sv
// neuron_mac_16_bit: serial multiply-accumulate neuron.
// Accumulates LEN exact Q8.24 products of signed Q4.12 pairs, adds the bias,
// then narrows with floor rounding and saturation back to Q4.12. The y output
// stays put from one out_valid pulse to the next.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start; in_valid ignored
// S_ACCUM  | accepting x/w pairs; in_valid=0 cycles are stalls
// S_FINISH | one cycle: add bias, narrow, saturate, register y, pulse

module neuron_mac_16_bit #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int LEN   = 8,
    parameter int ACC_W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] w,
    input  logic [N-1:0] bias,
    output logic         busy,
    output logic         out_valid,
    output logic [N-1:0] y
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [N-1:0]       r_y;
    logic                      r_out_valid;

    logic signed [2*N-1:0]     w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_bias_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_res;
    logic        [ACC_W-N:0]   w_res_hi;
    logic        [N-1:0]       w_sat;

    // Exact product, bias alignment to the Q8.24 accumulator grid, floor and saturate
    always_comb begin
        w_prod     = $signed(x) * $signed(w);
        w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};
        w_bias_ext = {{(ACC_W-N-Q){bias[N-1]}}, bias, {Q{1'b0}}};
        w_sum      = r_acc + w_bias_ext;
        w_res      = w_sum >>> Q;
        // In range only when every bit from the N-bit sign position up agrees
        w_res_hi   = w_res[ACC_W-1:N-1];
        w_sat      = w_res[N-1:0];
        if (!((&w_res_hi) || !(|w_res_hi))) begin
            w_sat = w_res[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    // Sequencing FSM with accumulator, pair counter and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (start) begin
                // Start from any state clears the sum; an aborted sum never reports
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= S_ACCUM;
            end else begin
                case (r_state)
                    S_ACCUM: begin
                        if (in_valid) begin
                            r_acc <= r_acc + w_prod_ext;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == LAST_IDX) begin
                                r_state <= S_FINISH;
                            end
                        end
                    end
                    S_FINISH: begin
                        r_y         <= w_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;

endmodule

// File: tb/tb_neuron_mac_16_bit.sv
// tb_neuron_mac_16_bit: directed-vector bench for neuron_mac_16_bit.
// Inputs change 1 ns after each rising edge; outputs are sampled at that point.

module tb_neuron_mac_16_bit;

    localparam int N   = 16;
    localparam int LEN = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [N-1:0]  x;
    logic [N-1:0]  w;
    logic [N-1:0]  bias;
    logic          busy;
    logic          out_valid;
    logic [N-1:0]  y;

    int total;
    int bad;
    int n_pulse;

    typedef struct {
        string        name;
        logic [N-1:0] x;
        logic [N-1:0] w;
        logic [N-1:0] bias;
        bit           stall;
        logic [N-1:0] exp_y;
    } vec_t;

    vec_t vecs[7];

    neuron_mac_16_bit #(.N(N), .Q(12), .LEN(LEN), .ACC_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .x         (x),
        .w         (w),
        .bias      (bias),
        .busy      (busy),
        .out_valid (out_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every out_valid cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid === 1'b1) n_pulse++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Feed one start plus LEN pairs; lat = edges from the start edge to out_valid
    task automatic run_dot(input vec_t v, output int lat);
        bias     = v.bias;
        start    = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b0;
        lat   = 0;
        chk({v.name, " busy_after_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < LEN; i++) begin
            x        = v.x;
            w        = v.w;
            in_valid = 1'b1;
            step();
            lat++;
            in_valid = 1'b0;
            if (v.stall && i < LEN - 1) begin
                x = N'($urandom);
                w = N'($urandom);
                step();
                lat++;
            end
        end
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   p0;
        logic [N-1:0] y_hold;

        total = 0;
        bad   = 0;
        n_pulse = 0;

        vecs[0] = '{"basic",    16'h1000, 16'h0800, 16'h0000, 1'b0, 16'h4000};
        vecs[1] = '{"bias_stl", 16'h0400, 16'h1000, 16'hF000, 1'b1, 16'h1000};
        vecs[2] = '{"sat_pos",  16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 16'h7FFF};
        vecs[3] = '{"sat_neg",  16'h7FFF, 16'h8000, 16'h0000, 1'b0, 16'h8000};
        vecs[4] = '{"floor_m1", 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'hFFFF};
        vecs[5] = '{"neg_bias", 16'hF000, 16'h1000, 16'h0800, 1'b0, 16'h8800};
        vecs[6] = '{"trunc",    16'h0003, 16'h0555, 16'h0000, 1'b0, 16'h0007};

        // Reset with garbage on the inputs
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; x = '0; w = '0; bias = '0;
        for (int i = 0; i < 2; i++) begin
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            x        = N'($urandom);
            w        = N'($urandom);
            step();
        end
        chk("rst_y", 32'(y), 32'h0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        p0 = n_pulse;
        for (int i = 0; i < 20; i++) step();
        chk("idle_no_pulse", 32'(n_pulse - p0), 32'd0);

        // Reset in the middle of accumulation
        p0 = n_pulse;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 16'h1000; w = 16'h1000; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) step();
        chk("midrst_no_pulse", 32'(n_pulse - p0), 32'd0);
        chk("midrst_y", 32'(y), 32'h0000);

        // Table-driven dot products
        for (int k = 0; k < 7; k++) begin
            p0 = n_pulse;
            run_dot(vecs[k], lat);
            chk({vecs[k].name, " latency"}, 32'(lat), 32'(LEN + 1 + (vecs[k].stall ? LEN - 1 : 0)));
            chk({vecs[k].name, " y"}, 32'(y), 32'(vecs[k].exp_y));
            chk({vecs[k].name, " busy_at_valid"}, 32'(busy), 32'd0);
            step();
            chk({vecs[k].name, " pulse_width"}, 32'(out_valid), 32'd0);
            chk({vecs[k].name, " y_hold"}, 32'(y), 32'(vecs[k].exp_y));
            chk({vecs[k].name, " pulse_count"}, 32'(n_pulse - p0), 32'd1);
        end

        // Restart during ACCUM; the start-cycle pair must not be taken
        y_hold = y;
        p0 = n_pulse;
        bias = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 16'h1000; w = 16'h1000; in_valid = 1'b1;
            step();
        end
        start = 1'b1; in_valid = 1'b1; x = 16'h1000; w = 16'h1000;
        step();
        start = 1'b0;
        chk("abort_no_pulse", 32'(n_pulse - p0), 32'd0);
        chk("abort_y_held", 32'(y), 32'(y_hold));
        lat = 0;
        for (int i = 0; i < LEN; i++) begin
            x = 16'h0800; w = 16'h1000; in_valid = 1'b1;
            step();
            lat++;
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        chk("restart_latency", 32'(lat), 32'(LEN + 1));
        chk("restart_y", 32'(y), 32'h4000);
        step();
        chk("restart_pulses", 32'(n_pulse - p0), 32'd1);

        // Restart landing in FINISH: no result, y untouched, later run completes
        y_hold = y;
        p0 = n_pulse;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            x = 16'h1000; w = 16'h1000; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("finish_abort_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("finish_abort_no_pulse", 32'(n_pulse - p0), 32'd0);
        chk("finish_abort_y", 32'(y), 32'(y_hold));
        lat = 0;
        for (int i = 0; i < LEN; i++) begin
            x = 16'h1000; w = 16'h0400; in_valid = 1'b1;
            step();
            lat++;
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        chk("after_abort_y", 32'(y), 32'h2000);
        step();
        chk("after_abort_pulses", 32'(n_pulse - p0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
